// File: rtl/f2h_arb_pkg.sv
// Shared types for the two-port SDRAM read arbiter: port ids, tracking entries, command FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package f2h_arb_pkg;

  // Width kept per tracked burst; requester burstcounts are zero-extended into it,
  // so BURST_W must not exceed this value.
  localparam int TRACK_BURST_W = 16;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    port_id_t                 port;
    logic [TRACK_BURST_W-1:0] burstcount;
  } track_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/arb_track_fifo.sv
// In-order record of accepted bursts: one {port, burstcount} entry per outstanding burst.
// Latency: push/pop take effect on the next clock edge; head is read straight from storage registers.
// Backpressure: push ignored when full, pop ignored when empty; the owner gates both with full/empty.
module arb_track_fifo
  import f2h_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  track_entry_t push_entry,
  input  logic         pop,
  output track_entry_t head,
  output logic         full,
  output logic         empty
);

  // DEPTH is a power of two (>= 2), so the pointers wrap naturally.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  track_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Entry storage: written on push only, contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/f2h_sdram_read_arbiter.sv
// Shares the read-only f2h_sdram port between the video reader (port 0, priority) and an aux reader (port 1).
// Latency: zero added cycles on command and return paths (combinational muxing/routing).
// Backpressure: s_waitrequest passed to the granted port; both ports stalled while the burst tracker is full.
// Optional ARB_STARVE_GUARD_EN: after STARVE_LIMIT port-0 grants with port 1 waiting, port 1 gets one grant.
module f2h_sdram_read_arbiter
  import f2h_arb_pkg::*;
#(
  parameter int ADDR_W       = 29,
  parameter int DATA_W       = 64,
  parameter int BURST_W      = 8,
  parameter int TRACK_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic [BURST_W-1:0] s_burstcount,
  output logic              s_read,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              grant_o
);

  cmd_state_t               state;
  cmd_state_t               state_nxt;
  port_id_t                 sel;
  logic                     req;
  logic                     run_en;
  logic                     accept;
  logic                     starve_force;
  logic                     trk_full;
  logic                     trk_empty;
  track_entry_t             trk_head;
  track_entry_t             push_entry;
  logic                     beat_ok;
  logic                     last_beat;
  logic                     cnt_loaded;
  logic [TRACK_BURST_W-1:0] beats_left;
  logic [TRACK_BURST_W-1:0] beat_rem;

  // Command outputs stay quiet while in reset and for the first edge after release,
  // independent of what the requesters are driving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  // Command FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a stalled command locks the grant; acceptance (or the owner withdrawing) releases it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (s_read && s_waitrequest) state_nxt = (sel == PORT1) ? LOCK1 : LOCK0;
      LOCK0, LOCK1: if (accept || !req) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Grant selection: port 0 first unless the starvation guard has tripped; frozen while locked.
  always_comb begin
    sel = PORT0;
    req = 1'b0;
    case (state)
      IDLE: begin
        if (starve_force && m1_read) begin
          sel = PORT1;
          req = 1'b1;
        end else if (m0_read) begin
          sel = PORT0;
          req = 1'b1;
        end else if (m1_read) begin
          sel = PORT1;
          req = 1'b1;
        end
      end
      LOCK0: begin
        sel = PORT0;
        req = m0_read;
      end
      LOCK1: begin
        sel = PORT1;
        req = m1_read;
      end
      default: begin
        sel = PORT0;
        req = 1'b0;
      end
    endcase
  end

  assign s_read         = run_en && req && !trk_full;
  assign s_address      = s_read ? ((sel == PORT1) ? m1_address : m0_address) : '0;
  assign s_burstcount   = s_read ? ((sel == PORT1) ? m1_burstcount : m0_burstcount) : '0;
  assign m0_waitrequest = !(s_read && (sel == PORT0)) || s_waitrequest;
  assign m1_waitrequest = !(s_read && (sel == PORT1)) || s_waitrequest;
  assign grant_o        = run_en && (sel == PORT1);
  assign accept         = s_read && !s_waitrequest;
  assign push_entry     = {sel, TRACK_BURST_W'(s_burstcount)};

  arb_track_fifo #(
    .DEPTH (TRACK_DEPTH)
  ) u_track (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (last_beat),
    .head       (trk_head),
    .full       (trk_full),
    .empty      (trk_empty)
  );

  // Return path: beats with nothing outstanding are dropped; a zero burstcount is
  // treated as a single beat so a bad request cannot wedge the tracker.
  assign beat_ok          = s_readdatavalid && !trk_empty;
  assign beat_rem         = cnt_loaded ? beats_left : trk_head.burstcount;
  assign last_beat        = beat_ok && (beat_rem <= TRACK_BURST_W'(1));
  assign m0_readdatavalid = beat_ok && (trk_head.port == PORT0);
  assign m1_readdatavalid = beat_ok && (trk_head.port == PORT1);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  // Beat counter: picks up the head burstcount on the first beat, counts down to the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_loaded <= 1'b0;
      beats_left <= '0;
    end else if (last_beat) begin
      cnt_loaded <= 1'b0;
    end else if (beat_ok) begin
      cnt_loaded <= 1'b1;
      beats_left <= beat_rem - TRACK_BURST_W'(1);
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  // Counts port-0 grants taken while port 1 waits; a port-1 grant or port 1 idling clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!m1_read || (accept && (sel == PORT1))) begin
      starve_cnt <= '0;
    end else if (accept && (sel == PORT0) && !starve_force) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  assign starve_force = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
`else
  assign starve_force = 1'b0;
`endif

endmodule

// File: tb/tb_f2h_sdram_read_arbiter.sv
// Directed bench for f2h_sdram_read_arbiter: bench plays both requesters and the SDRAM port.
// Status vector st = {s_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, grant_o}.
// Inputs driven 2 ns after the rising edge, outputs sampled 1 ns later.
`timescale 1ns/1ps
module tb_f2h_sdram_read_arbiter;

  localparam int ADDR_W  = 29;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;
  localparam int DEPTH   = 4;
  localparam int LIMIT   = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [ADDR_W-1:0]  m0_address = '0, m1_address = '0;
  logic [BURST_W-1:0] m0_burstcount = '0, m1_burstcount = '0;
  logic               m0_read = 1'b0, m1_read = 1'b0;
  logic               m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0]  m0_readdata, m1_readdata;
  logic               m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0]  s_address;
  logic [BURST_W-1:0] s_burstcount;
  logic               s_read;
  logic               s_waitrequest = 1'b0;
  logic [DATA_W-1:0]  s_readdata = '0;
  logic               s_readdatavalid = 1'b0;
  logic               grant_o;

  int checks = 0;
  int errors = 0;
  int bc0_seen = 0;

  wire [5:0] st = {s_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, grant_o};

  f2h_sdram_read_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TRACK_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .grant_o(grant_o)
  );

  always #10 clk = ~clk;

  // Burstcount 0 from a requester is illegal; note it whenever a requester drives one.
  always @(negedge clk) begin
    if (rst_n && ((m0_read && m0_burstcount == '0) || (m1_read && m1_burstcount == '0))) begin
      bc0_seen++;
      $display("note: illegal burstcount 0 driven by a requester at %0t", $time);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m1_read = 1'b0;
    m0_address = '0; m1_address = '0;
    m0_burstcount = '0; m1_burstcount = '0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_read = 1'b1; m0_address = ADDR_W'(32'h1234); m0_burstcount = 8'd4;
    m1_read = 1'b1; m1_address = ADDR_W'(32'h5678); m1_burstcount = 8'd4;
    s_readdatavalid = 1'b1; s_readdata = 64'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (st !== 6'b011000 || s_address !== '0 || s_burstcount !== '0) begin
        errors++;
        $display("FAIL reset_values[%0d] st=%b addr=%h bc=%h required st=011000 addr=0 bc=0", i, st, s_address, s_burstcount);
      end
      cyc();
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_port0_stream();
    int acc = 0;
    int m0_ok = 0;
    int m1_hi = 0;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_dat;
    for (int k = 0; k < 4; k++) begin
      cyc();
      exp_addr = ADDR_W'(32'h100 + 8 * k);
      m0_read = 1'b1; m0_address = exp_addr; m0_burstcount = 8'd8; s_waitrequest = 1'b0;
      #1;
      if (s_read && !s_waitrequest) acc++;
      checks++;
      if (st !== 6'b101000 || s_address !== exp_addr || s_burstcount !== 8'd8) begin
        errors++;
        $display("FAIL p0_cmd[%0d] st=%b addr=%h bc=%0d required st=101000 addr=%h bc=8", k, st, s_address, s_burstcount, exp_addr);
      end
    end
    for (int b = 0; b < 32; b++) begin
      cyc();
      m0_read = 1'b0;
      exp_dat = DATA_W'(32'h100 + b);
      s_readdatavalid = 1'b1; s_readdata = exp_dat;
      #1;
      if (m0_readdatavalid && m0_readdata === exp_dat) m0_ok++;
      if (m1_readdatavalid) m1_hi++;
    end
    checks++;
    if (acc !== 4) begin
      errors++;
      $display("FAIL p0_accepts got %0d required 4", acc);
    end
    checks++;
    if (m0_ok !== 32 || m1_hi !== 0) begin
      errors++;
      $display("FAIL p0_beats m0_in_order=%0d m1_valid=%0d required 32 and 0", m0_ok, m1_hi);
    end
    // Tracker is now empty: a stray beat must go nowhere.
    cyc();
    s_readdatavalid = 1'b1;
    #1;
    checks++;
    if (st !== 6'b011000) begin
      errors++;
      $display("FAIL stray_beat_empty st=%b required 011000", st);
    end
    cyc();
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_lock();
    for (int i = 0; i < 3; i++) begin
      cyc();
      m0_read = 1'b1; m0_address = ADDR_W'(32'hA00); m0_burstcount = 8'd1;
      m1_read = 1'b1; m1_address = ADDR_W'(32'hB00); m1_burstcount = 8'd1;
      s_waitrequest = 1'b1;
      #1;
      checks++;
      if (st !== 6'b111000 || s_address !== ADDR_W'(32'hA00)) begin
        errors++;
        $display("FAIL lock0_stall[%0d] st=%b addr=%h required st=111000 addr=a00", i, st, s_address);
      end
    end
    cyc();
    s_waitrequest = 1'b0;
    #1;
    checks++;
    if (st !== 6'b101000) begin
      errors++;
      $display("FAIL lock0_accept st=%b required 101000", st);
    end
    cyc();
    m0_read = 1'b0;
    #1;
    checks++;
    if (st !== 6'b110001 || s_address !== ADDR_W'(32'hB00)) begin
      errors++;
      $display("FAIL lock_p1_next st=%b addr=%h required st=110001 addr=b00", st, s_address);
    end
    cyc();
    m1_read = 1'b0; s_readdatavalid = 1'b1;
    #1;
    checks++;
    if (st !== 6'b011100) begin
      errors++;
      $display("FAIL lock_ret0 st=%b required 011100", st);
    end
    cyc();
    #1;
    checks++;
    if (st !== 6'b011010) begin
      errors++;
      $display("FAIL lock_ret1 st=%b required 011010", st);
    end
    cyc();
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_interleave();
    logic [5:0] exp_tab [7];
    exp_tab = '{6'b101000, 6'b110101, 6'b101100, 6'b011010, 6'b011010, 6'b011010, 6'b011100};
    for (int c = 0; c < 7; c++) begin
      cyc();
      m0_read = (c == 0) || (c == 2);
      m0_burstcount = (c == 0) ? 8'd2 : 8'd1;
      m1_read = (c == 1);
      m1_burstcount = 8'd3;
      s_readdatavalid = (c >= 1);
      #1;
      checks++;
      if (st !== exp_tab[c]) begin
        errors++;
        $display("FAIL interleave[%0d] st=%b required %b", c, st, exp_tab[c]);
      end
    end
    cyc();
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      cyc();
      m1_read = 1'b1; m1_address = ADDR_W'(32'h200 + 2 * k); m1_burstcount = 8'd2;
      #1;
      checks++;
      if (st !== 6'b110001) begin
        errors++;
        $display("FAIL full_fill[%0d] st=%b required 110001", k, st);
      end
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      m0_read = 1'b1; m0_burstcount = 8'd1; m1_read = 1'b1;
      s_readdatavalid = (c >= 2);
      #1;
      checks++;
      if (st !== ((c >= 2) ? 6'b011010 : 6'b011000) || s_address !== '0) begin
        errors++;
        $display("FAIL full_block[%0d] st=%b addr=%h required st=%b addr=0", c, st, s_address,
                 (c >= 2) ? 6'b011010 : 6'b011000);
      end
    end
    cyc();
    s_readdatavalid = 1'b0;
    #1;
    checks++;
    if (st !== 6'b101000) begin
      errors++;
      $display("FAIL full_reopen st=%b required 101000", st);
    end
    cyc();
    m0_read = 1'b0;
    #1;
    checks++;
    if (st !== 6'b011001) begin
      errors++;
      $display("FAIL full_again st=%b required 011001", st);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_starve();
    logic g;
    logic pg = 1'b0;
    logic [5:0] exp_st;
    for (int c = 0; c < 19; c++) begin
      cyc();
      m0_read = (c < 18); m0_burstcount = 8'd1;
      m1_read = (c < 18); m1_burstcount = 8'd1;
      s_waitrequest = 1'b0;
      s_readdatavalid = (c >= 1);
      g = GUARD && (c < 18) && ((c % 9) == 8);
      if (c < 18) exp_st = {1'b1, g, ~g, 1'b0, 1'b0, g};
      else        exp_st = 6'b011000;
      exp_st[2] = (c >= 1) && !pg;
      exp_st[1] = (c >= 1) && pg;
      #1;
      checks++;
      if (st !== exp_st) begin
        errors++;
        $display("FAIL starve[%0d] st=%b required %b", c, st, exp_st);
      end
      pg = g;
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_zero_burst();
    int seen0 = bc0_seen;
    cyc();
    m0_read = 1'b1; m0_address = ADDR_W'(32'h300); m0_burstcount = 8'd0; s_waitrequest = 1'b1;
    #1;
    checks++;
    if (st !== 6'b111000 || s_burstcount !== 8'd0) begin
      errors++;
      $display("FAIL zero_bc_forward st=%b bc=%0d required st=111000 bc=0", st, s_burstcount);
    end
    #8;
    checks++;
    if (bc0_seen !== seen0 + 1) begin
      errors++;
      $display("FAIL zero_bc_flag seen=%0d required %0d", bc0_seen, seen0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    m0_read = 1'b1; m0_address = ADDR_W'(32'h400); m0_burstcount = 8'd4; s_waitrequest = 1'b0;
    #1;
    checks++;
    if (st !== 6'b101000) begin
      errors++;
      $display("FAIL rmid_cmd0 st=%b required 101000", st);
    end
    cyc();
    m0_read = 1'b0; m1_read = 1'b1; m1_address = ADDR_W'(32'h500); m1_burstcount = 8'd4;
    s_readdatavalid = 1'b1;
    #1;
    checks++;
    if (st !== 6'b110101) begin
      errors++;
      $display("FAIL rmid_cmd1 st=%b required 110101", st);
    end
    cyc();
    m1_read = 1'b0;
    #1;
    checks++;
    if (st !== 6'b011100) begin
      errors++;
      $display("FAIL rmid_beat st=%b required 011100", st);
    end
    #2;
    rst_n = 1'b0;
    m0_read = 1'b1;
    #1;
    checks++;
    if (st !== 6'b011000 || s_address !== '0 || s_burstcount !== '0) begin
      errors++;
      $display("FAIL rmid_in_reset st=%b addr=%h bc=%h required st=011000 addr=0 bc=0", st, s_address, s_burstcount);
    end
    cyc();
    rst_n = 1'b1; m0_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      s_readdatavalid = 1'b1;
      #1;
      checks++;
      if (st !== 6'b011000) begin
        errors++;
        $display("FAIL rmid_stray[%0d] st=%b required 011000", i, st);
      end
    end
    cyc();
    s_readdatavalid = 1'b0; m1_read = 1'b1; m1_burstcount = 8'd1;
    #1;
    checks++;
    if (st !== 6'b110001) begin
      errors++;
      $display("FAIL rmid_new_cmd st=%b required 110001", st);
    end
    cyc();
    m1_read = 1'b0; s_readdatavalid = 1'b1;
    #1;
    checks++;
    if (st !== 6'b011010) begin
      errors++;
      $display("FAIL rmid_new_route st=%b required 011010", st);
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_port0_stream();
    test_lock();
    test_interleave();
    test_full();
    test_reset();
    test_starve();
    test_zero_burst();
    test_reset();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
